// File: rtl/rle_pkg.sv
// -----------------------------------------------------------------------------
// rle_pkg
// Shared definitions for the RLE datapath (decoder and compressor).
//   - rle_state_e     : decoder FSM states
//   - pair layout     : a 16-bit pair is {symbol[15:8], count[7:0]}; a 32-bit
//                       word holds pair 0 in [15:0] and pair 1 in [31:16]
//   - pair_sym/pair_cnt : extract symbol/count of pair idx from a word
// -----------------------------------------------------------------------------
package rle_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_EXPAND = 3'd3,
        S_WRITE  = 3'd4,
        S_FLUSH  = 3'd5,
        S_FINISH = 3'd6
    } rle_state_e;

    localparam int SYM_HI         = 15;
    localparam int SYM_LO         = 8;
    localparam int CNT_HI         = 7;
    localparam int CNT_LO         = 0;
    localparam int PAIR_W         = 16;
    localparam int PAIRS_PER_WORD = 2;

    function automatic logic [7:0] pair_sym(input logic [31:0] w, input logic idx);
        logic [PAIR_W-1:0] p;
        p = idx ? w[2*PAIR_W-1:PAIR_W] : w[PAIR_W-1:0];
        return p[SYM_HI:SYM_LO];
    endfunction

    function automatic logic [7:0] pair_cnt(input logic [31:0] w, input logic idx);
        logic [PAIR_W-1:0] p;
        p = idx ? w[2*PAIR_W-1:PAIR_W] : w[PAIR_W-1:0];
        return p[CNT_HI:CNT_LO];
    endfunction

endpackage

// File: rtl/rle_byte_packer.sv
// -----------------------------------------------------------------------------
// rle_byte_packer
// Packs bytes little-endian into a 32-bit word (first byte in [7:0]).
//   clk, nreset   : clock, async active-low reset
//   byte_i/valid_i: byte to append when valid_i is high
//   take_i        : clear the buffer (word consumed or abandoned)
//   fill_o        : bytes currently held, modulo 4
//   word_full_o   : the byte pushed this cycle completes the word
//   word_o        : buffer contents; unfilled lanes are always zero, so this
//                   is also the zero-padded word for a flush
// -----------------------------------------------------------------------------
module rle_byte_packer (
    input  logic        clk,
    input  logic        nreset,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    input  logic        take_i,
    output logic [1:0]  fill_o,
    output logic        word_full_o,
    output logic [31:0] word_o
);

    logic [1:0]  fill_q;
    logic [31:0] data_q;

    // fill_q wraps to 0 on the fourth byte; the full word stays in data_q
    // until the owner takes it, and nothing is pushed in between.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fill_q <= 2'd0;
            data_q <= 32'd0;
        end else if (take_i) begin
            fill_q <= 2'd0;
            data_q <= 32'd0;
        end else if (valid_i) begin
            data_q[{fill_q, 3'b000} +: 8] <= byte_i;
            fill_q                        <= fill_q + 2'd1;
        end
    end

    assign fill_o      = fill_q;
    assign word_full_o = valid_i && (fill_q == 2'd3);
    assign word_o      = data_q;

endmodule

// File: rtl/rle_decoder.sv
// -----------------------------------------------------------------------------
// rle_decoder
// Expands a frame of {symbol,count} pairs read from the dpsram (port A) into
// plaintext written back to the same dpsram.
//   clk, nreset          : clock, async active-low reset
//   start                : pulse to begin a decode (ignored while busy)
//   rle_addr, rle_size   : compressed frame byte address / length in bytes
//   message_addr         : plaintext destination byte address
//   message_size         : plaintext bytes produced (saturating)
//   done                 : high in idle after a completed decode
//   port_A_*             : single-port SRAM interface (byte addresses,
//                          1-cycle registered read data)
// -----------------------------------------------------------------------------
module rle_decoder
    import rle_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int SIZE_W = 32
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [SIZE_W-1:0] rle_size,
    input  logic [31:0]       message_addr,
    output logic [SIZE_W-1:0] message_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
);

    rle_state_e        state_q, ret_q, nxt;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q, addr_q;
    logic [SIZE_W-1:0] pairs_left_q, msize_q;
    logic [31:0]       word_q;
    logic [7:0]        cnt_q;
    logic              pidx_q, we_q, done_q;

    logic        push, pair_end, take, pk_full;
    logic [1:0]  pk_fill;
    logic [31:0] pk_word;
    logic [7:0]  sym;

    always_comb begin
        sym      = pair_sym(word_q, pidx_q);
        push     = (state_q == S_EXPAND) && (cnt_q != 8'd0);
        // The last byte of a pair and the move to the next pair share a
        // cycle; a count-0 pair costs one idle cycle.
        pair_end = (cnt_q <= 8'd1);
        if (pairs_left_q == SIZE_W'(1))
            nxt = S_FLUSH;
        else if (pidx_q)
            nxt = S_FETCH;
        else
            nxt = S_EXPAND;
        take = (state_q == S_WRITE) || (state_q == S_FLUSH) ||
               ((state_q == S_IDLE) && start);
    end

    rle_byte_packer u_packer (
        .clk         (clk),
        .nreset      (nreset),
        .byte_i      (sym),
        .valid_i     (push),
        .take_i      (take),
        .fill_o      (pk_fill),
        .word_full_o (pk_full),
        .word_o      (pk_word)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            ret_q        <= S_IDLE;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            addr_q       <= '0;
            pairs_left_q <= '0;
            msize_q      <= '0;
            word_q       <= '0;
            cnt_q        <= '0;
            pidx_q       <= 1'b0;
            we_q         <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    we_q <= 1'b0;
                    if (start) begin
                        rd_addr_q    <= rle_addr[ADDR_W-1:0];
                        wr_addr_q    <= message_addr[ADDR_W-1:0];
                        pairs_left_q <= {1'b0, rle_size[SIZE_W-1:1]};
                        msize_q      <= '0;
                        done_q       <= 1'b0;
                        if (rle_size[SIZE_W-1:1] != '0) begin
                            state_q <= S_FETCH;
                            addr_q  <= rle_addr[ADDR_W-1:0];
                        end else begin
                            state_q <= S_FINISH;
                        end
                    end
                end
                S_FETCH: begin
                    rd_addr_q <= rd_addr_q + ADDR_W'(4);
                    state_q   <= S_LATCH;
                end
                S_LATCH: begin
                    word_q  <= port_A_data_out;
                    pidx_q  <= 1'b0;
                    cnt_q   <= pair_cnt(port_A_data_out, 1'b0);
                    state_q <= S_EXPAND;
                end
                S_EXPAND: begin
                    if (push) begin
                        cnt_q <= cnt_q - 8'd1;
                        if (msize_q != '1)
                            msize_q <= msize_q + SIZE_W'(1);
                    end
                    if (pair_end) begin
                        pairs_left_q <= pairs_left_q - SIZE_W'(1);
                        if (nxt == S_EXPAND) begin
                            pidx_q <= 1'b1;
                            cnt_q  <= pair_cnt(word_q, 1'b1);
                        end
                    end
                    // A full word is written first; ret_q remembers where
                    // expansion would have gone.
                    if (pk_full) begin
                        state_q <= S_WRITE;
                        we_q    <= 1'b1;
                        addr_q  <= wr_addr_q;
                        ret_q   <= pair_end ? nxt : S_EXPAND;
                    end else if (pair_end) begin
                        state_q <= nxt;
                        if (nxt == S_FETCH)
                            addr_q <= rd_addr_q;
                        if (nxt == S_FLUSH && (push || pk_fill != 2'd0)) begin
                            we_q   <= 1'b1;
                            addr_q <= wr_addr_q;
                        end
                    end
                end
                S_WRITE: begin
                    we_q      <= 1'b0;
                    wr_addr_q <= wr_addr_q + ADDR_W'(4);
                    state_q   <= ret_q;
                    if (ret_q == S_FETCH)
                        addr_q <= rd_addr_q;
                end
                S_FLUSH: begin
                    we_q <= 1'b0;
                    if (we_q)
                        wr_addr_q <= wr_addr_q + ADDR_W'(4);
                    state_q <= S_FINISH;
                end
                S_FINISH: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign port_A_clk     = clk;
    assign port_A_addr    = addr_q;
    assign port_A_we      = we_q;
    assign port_A_data_in = pk_word;
    assign message_size   = msize_q;
    assign done           = done_q;

    // Address bits above ADDR_W, rle_size[0] and the pair-0 count held in
    // word_q (read straight from the SRAM at LATCH) are intentionally unused.
    logic unused_ok;
    assign unused_ok = ^{rle_addr, message_addr, rle_size[0], word_q[7:0]};

endmodule

// File: tb/tb_rle_decoder.sv
module tb_rle_decoder;

    localparam logic [31:0] RLE_A = 32'h100;
    localparam logic [31:0] MSG_A = 32'h400;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rle_addr = RLE_A;
    logic [31:0] rle_size = 32'd0;
    logic [31:0] message_addr = MSG_A;
    logic [31:0] message_size;
    logic        done;
    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic        port_A_we;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out;

    rle_decoder dut (
        .clk             (clk),
        .nreset          (nreset),
        .start           (start),
        .rle_addr        (rle_addr),
        .rle_size        (rle_size),
        .message_addr    (message_addr),
        .message_size    (message_size),
        .done            (done),
        .port_A_clk      (port_A_clk),
        .port_A_addr     (port_A_addr),
        .port_A_we       (port_A_we),
        .port_A_data_in  (port_A_data_in),
        .port_A_data_out (port_A_data_out)
    );

    always #5 clk = ~clk;

    // Compressed-frame memory (read side) and write recorder.
    logic [31:0] rom [0:1023];
    always @(posedge clk) port_A_data_out <= rom[port_A_addr[11:2]];

    int          wr_total = 0;
    logic [31:0] wr_d [0:4095];
    logic [15:0] wr_a [0:4095];
    always @(posedge clk) begin
        if (port_A_we) begin
            wr_d[wr_total[11:0]] <= port_A_data_in;
            wr_a[wr_total[11:0]] <= port_A_addr;
            wr_total             <= wr_total + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rsize;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] msz;
        int          nwr;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    vec_t tv [10];

    task automatic pulse_start(input logic [31:0] rsz);
        @(negedge clk);
        rle_size = rsz;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int base;
        int nw;
        rom[RLE_A[11:2]]        = v.w0;
        rom[RLE_A[11:2] + 10'd1] = v.w1;
        base = wr_total;
        pulse_start(v.rsize);
        chk({name, "_done_drop"}, {31'd0, done}, 32'd0);
        wait_done(name);
        nw = wr_total - base;
        chk({name, "_msize"}, message_size, v.msz);
        chk({name, "_nwr"}, nw, v.nwr);
        if (v.nwr > 0 && nw > 0) begin
            chk({name, "_first"}, wr_d[base[11:0]], v.first);
            chk({name, "_first_addr"}, {16'd0, wr_a[base[11:0]]}, MSG_A);
            chk({name, "_last"}, wr_d[12'(base + nw - 1)], v.last);
            chk({name, "_last_addr"}, {16'd0, wr_a[12'(base + nw - 1)]},
                MSG_A + 32'(4 * (v.nwr - 1)));
        end
        repeat (3) @(negedge clk);
        chk({name, "_msize_stable"}, message_size, v.msz);
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < 1024; i++) rom[i] = 32'd0;

        //            rsize  w0            w1            msz  nwr first         last
        tv[0] = '{32'd4, 32'h00004103, 32'h0,        32'd3,   1,  32'h00414141, 32'h00414141};
        tv[1] = '{32'd4, 32'h42024103, 32'h0,        32'd5,   2,  32'h42414141, 32'h00000042};
        tv[2] = '{32'd2, 32'h42024103, 32'h0,        32'd3,   1,  32'h00414141, 32'h00414141};
        tv[3] = '{32'd3, 32'h42024103, 32'h0,        32'd3,   1,  32'h00414141, 32'h00414141};
        tv[4] = '{32'd4, 32'h43020000, 32'h0,        32'd2,   1,  32'h00004343, 32'h00004343};
        tv[5] = '{32'd4, 32'h00004404, 32'h0,        32'd4,   1,  32'h44444444, 32'h44444444};
        tv[6] = '{32'd8, 32'h42014101, 32'h44024301, 32'd5,   2,  32'h44434241, 32'h00000044};
        tv[7] = '{32'd6, 32'h42014101, 32'h44024301, 32'd3,   1,  32'h00434241, 32'h00434241};
        tv[8] = '{32'd4, 32'h00000000, 32'h0,        32'd0,   0,  32'h0,        32'h0};
        tv[9] = '{32'd4, 32'h00005AFF, 32'h0,        32'd255, 64, 32'h5A5A5A5A, 32'h005A5A5A};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_msize", message_size, 32'd0);
        chk("rst_we", {31'd0, port_A_we}, 32'd0);
        chk("rst_addr", {16'd0, port_A_addr}, 32'd0);
        chk("rst_data_in", port_A_data_in, 32'd0);
        nreset = 1'b1;

        // Empty frame: done two cycles after start, no SRAM traffic
        base = wr_total;
        pulse_start(32'd0);
        chk("empty_done_c1", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("empty_done_c2", {31'd0, done}, 32'd1);
        chk("empty_msize", message_size, 32'd0);
        chk("empty_addr", {16'd0, port_A_addr}, 32'd0);
        chk("empty_nwr", wr_total - base, 32'd0);

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tv[i]);

        // start while busy is ignored
        rom[RLE_A[11:2]] = 32'h00005AFF;
        base = wr_total;
        pulse_start(32'd4);
        repeat (10) @(negedge clk);
        rle_addr = 32'h200;
        start    = 1'b1;
        rle_size = 32'd2;
        @(negedge clk);
        start    = 1'b0;
        rle_addr = RLE_A;
        wait_done("busy");
        chk("busy_msize", message_size, 32'd255);
        chk("busy_nwr", wr_total - base, 32'd64);

        // Reset during a write of a 255 run
        pulse_start(32'd4);
        n = 0;
        while (!port_A_we && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_we_seen", {31'd0, port_A_we}, 32'd1);
        nreset = 1'b0;
        #1;
        chk("rst_mid_we", {31'd0, port_A_we}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        chk("rst_mid_msize", message_size, 32'd0);
        base = wr_total;
        repeat (5) @(negedge clk);
        chk("rst_mid_nwr", wr_total - base, 32'd0);
        nreset = 1'b1;
        run_vec("after_rst", tv[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
